cordic_rotator: RTL



---
 rtl/cordic_pkg.sv | 18 +
 rtl/cordic_microrot.sv | 29 ++
 rtl/cordic_rotator.sv | 102 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotation engine.
package cordic_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Gain compensation K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 (signs + + - -).
    localparam int unsigned K_SH0 = 1;
    localparam int unsigned K_SH1 = 3;
    localparam int unsigned K_SH2 = 6;
    localparam int unsigned K_SH3 = 9;

endpackage : cordic_pkg

// File: rtl/cordic_microrot.sv
// Single CORDIC micro-rotation: shift-and-add step by 2^-shift in direction dir.
module cordic_microrot #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SH_W  = 5
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic        [SH_W-1:0]  shift,
    input  logic                    dir,
    output logic signed [WIDTH-1:0] x_rot_c,
    output logic signed [WIDTH-1:0] y_rot_c
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    // dir=0 rotates counter-clockwise, dir=1 clockwise; sums wrap modulo 2^WIDTH.
    always_comb begin
        x_sh    = x >>> shift;
        y_sh    = y >>> shift;
        x_rot_c = x - y_sh;
        y_rot_c = y + x_sh;
        if (dir) begin
            x_rot_c = x + y_sh;
            y_rot_c = y - x_sh;
        end
    end

endmodule : cordic_microrot

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: replays a direction-bit sequence on (x, y),
// one micro-rotation per clock, then applies the fixed gain compensation.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned N_ITER = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic                    rot90,
    input  logic       [N_ITER-1:0] dirs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out
);

    state_t                  state_q;
    logic        [CNT_W-1:0] cnt_q;
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] y_q;
    logic       [N_ITER-1:0] dirs_q;
    logic signed [WIDTH-1:0] x_rot_c;
    logic signed [WIDTH-1:0] y_rot_c;

    // Multiply by K using the shift-add approximation, wrapping modulo 2^WIDTH.
    function automatic logic signed [WIDTH-1:0] gain_comp(input logic signed [WIDTH-1:0] v);
        return (v >>> K_SH0) + (v >>> K_SH1) - (v >>> K_SH2) - (v >>> K_SH3);
    endfunction

    assign in_ready = (state_q == IDLE);

    // Direction bits are consumed LSB-first, so dirs_q[0] always belongs to iteration cnt_q.
    cordic_microrot #(
        .WIDTH (WIDTH),
        .SH_W  (CNT_W)
    ) u_microrot (
        .x       (x_q),
        .y       (y_q),
        .shift   (cnt_q),
        .dir     (dirs_q[0]),
        .x_rot_c (x_rot_c),
        .y_rot_c (y_rot_c)
    );

    // Control FSM, iteration counter, working vector and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dirs_q    <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= rot90 ? -y_in : x_in;
                        y_q     <= rot90 ? x_in : y_in;
                        dirs_q  <= dirs;
                        cnt_q   <= '0;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    x_q    <= x_rot_c;
                    y_q    <= y_rot_c;
                    dirs_q <= dirs_q >> 1;
                    if (cnt_q == CNT_W'(N_ITER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SCALE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SCALE: begin
                    x_out     <= gain_comp(x_q);
                    y_out     <= gain_comp(y_q);
                    out_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : cordic_rotator
